attention_score_mh: RTL and testbench
=====================================

Name: attention_score_mh

Overview:
- Multi-head, streaming successor to the single-head attention-score block.
- For each head h, computes S_h = (Q_h · K_h^T) · scale with a single sequential MAC.
- Supports an optional causal mask and a runtime scale override.
- Emits scores one per beat over a valid/ready stream, in head-major, row-major order, to feed the softmax stage.

Parameters:
- DATA_WIDTH, 16, signed Q1.F element width, F = DATA_WIDTH-1.
- L, 16, sequence length (rows and cols per head).
- H, 2, number of heads.
- E, 32, per-head embedding dimension.
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(E)+1, signed accumulator width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a job; honoured only in IDLE
- causal_en  in  1  mask col>row; latched at start
- scale_ovr_en  in  1  use scale_in instead of the default; latched at start
- scale_in  in  DATA_WIDTH  unsigned Q0.F scale; latched at start
- Q_in  in  DATA_WIDTH x H*L*E  index h*L*E+r*E+e; held stable start..done
- K_in  in  DATA_WIDTH x H*L*E  same layout as Q_in; held stable start..done
- score_out  out  DATA_WIDTH  signed Q1.F score
- score_valid  out  1  score_out is valid
- score_ready  in  1  downstream accepts the score
- score_head  out  $clog2(H) (min 1)  head index of the current score
- score_row  out  $clog2(L) (min 1)  row index of the current score
- score_col  out  $clog2(L) (min 1)  col index of the current score
- score_last  out  1  high with the final score (H-1, L-1, L-1)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset, synchronous on clk while rst_n=0:
  - state <= IDLE.
  - score_out, score_valid, score_last, busy, done, all indices, accumulator and MAC counter <= 0.
  - Applies mid-job: the job is abandoned and no further beats are emitted.
- Default scale = min(round(2^F/sqrt(E)), 2^F-1), a compile-time constant. For E=1 it clips to 0x7FFF.
- States:
  - IDLE: on start, latch mode/scale, clear indices, go to CHECK.
  - CHECK: if causal_en and col>row: score_out<=0x8000 (DATA_WIDTH most-negative), go to OUT. Otherwise acc<=0, k<=0, go to MAC.
  - MAC: acc += Q[h,row,k]*K[h,col,k] (full-precision signed), one term per cycle for E cycles. After k=E-1, go to SCALE.
  - SCALE: one cycle; computes score_out (see arithmetic below), then go to OUT.
  - OUT: score_valid=1 with indices and score_last driven.
    - On valid&&ready: advance col; wrap col to 0 and advance row; wrap row and advance head.
    - If score_last, go to DONE; else go to CHECK.
    - No handshake: hold all outputs stable.
  - DONE: done=1 for one cycle, then go to IDLE.
- SCALE arithmetic:
  - p = acc * {0, scale}, signed, fraction bits 3F.
  - Add rounding bias 2^(2F-1) (round-half-up toward +inf), then arithmetic shift right 2F.
  - Saturate to [-2^F, 2^F-1].
- score_valid is asserted only in OUT and never drops without a handshake or reset.
- score_out and indices are registered; they change only on entering OUT.
- Latency with ready tied high:
  - Unmasked element: E+3 cycles (CHECK, E×MAC, SCALE, OUT).
  - Masked element: 2 cycles.
  - done comes 1 cycle after the last handshake.
- start while busy is ignored; the latched mode is unaffected.
- start asserted in the same cycle as DONE is ignored; it must be asserted again in IDLE.
- Q_in/K_in changing mid-job gives undefined scores but the protocol stays correct.

Test Plan:
- Config DATA_WIDTH=16, L=4, H=2, E=4 for all scenarios.
- Basic: all Q=K=0x4000, default scale 0x4000, ready=1 → 32 beats of 0x4000, order (0,0,0)..(1,3,3), score_last only on beat 32, done 1 cycle after it.
- Causal: same data, causal_en=1 → 12 beats of 0x8000 (col>row), 20 beats of 0x4000; masked beats 2 cycles apart.
- Saturation: scale_ovr_en=1, scale_in=0x7FFF, Q=K=0x7FFF → all 0x7FFF. Then with K=0x8000 → all 0x8000.
- Rounding: scale_in=0x4000, Q[*,*,0]=0x0100, rest 0.
  - K[*,*,0]=0x0080 → 0x0001 (+0.5 LSB rounds up).
  - K[*,*,0]=0xFF80 → 0x0000.
- Backpressure: hold ready low 5 cycles on beat 3, then toggle randomly → score_out and indices stable while stalled; all 32 beats are emitted exactly once, in order.
- Reset/start abuse:
  - rst_n low for 1 cycle during MAC of beat 5 → next cycle valid=0, busy=0. A new start then yields the full correct 32-beat sequence.
  - start pulses while busy → no effect.

Source files
------------

// File: rtl/attention_score_mh.sv
`default_nettype none
// ============================================================================
//  Module      : attention_score_mh
//  Description : Multi-head streaming attention-score engine. For each head
//                computes S = (Q * K^T) * scale with one sequential MAC and
//                emits the scores over a valid/ready stream in head-major,
//                row-major order. Optional causal mask, runtime scale override.
//  Revision    : 1.0 - initial release
// ============================================================================
module attention_score_mh #(
  parameter int DATA_WIDTH = 16,
  parameter int L          = 16,
  parameter int H          = 2,
  parameter int E          = 32,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(E)+1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 causal_en,
  input  logic                                 scale_ovr_en,
  input  logic [DATA_WIDTH-1:0]                scale_in,
  input  logic [H*L*E*DATA_WIDTH-1:0]          Q_in,
  input  logic [H*L*E*DATA_WIDTH-1:0]          K_in,
  output logic [DATA_WIDTH-1:0]                score_out,
  output logic                                 score_valid,
  input  logic                                 score_ready,
  output logic [((H > 1) ? $clog2(H) : 1)-1:0] score_head,
  output logic [((L > 1) ? $clog2(L) : 1)-1:0] score_row,
  output logic [((L > 1) ? $clog2(L) : 1)-1:0] score_col,
  output logic                                 score_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int F  = DATA_WIDTH - 1;
  localparam int HW = (H > 1) ? $clog2(H) : 1;
  localparam int LW = (L > 1) ? $clog2(L) : 1;
  localparam int KW = (E > 1) ? $clog2(E) : 1;
  localparam int N  = H * L * E;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = ACC_WIDTH + DATA_WIDTH + 1;

  // Largest x with (2x-1)^2 * E <= 4 * 2^(2F), i.e. round-half-up of
  // 2^F / sqrt(E), then clipped to the largest positive Q0.F code.
  function automatic logic [DATA_WIDTH-1:0] calc_default_scale();
    logic [63:0] x;
    logic [63:0] t;
    logic [63:0] lim;
    logic [63:0] top;
    x   = '0;
    lim = 64'd1 << (2*F + 2);
    top = (64'd1 << F) - 64'd1;
    for (int b = DATA_WIDTH; b >= 0; b--) begin
      t = x | (64'd1 << b);
      if ((64'd2*t - 64'd1) * (64'd2*t - 64'd1) * 64'(E) <= lim) x = t;
    end
    if (x > top) x = top;
    return x[DATA_WIDTH-1:0];
  endfunction

  localparam logic [DATA_WIDTH-1:0] DEFAULT_SCALE = calc_default_scale();
  localparam logic [DATA_WIDTH-1:0] MASK_SCORE    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]  ONE           = PW'(1);
  localparam logic signed [PW-1:0]  SAT_MAX       = (ONE << F) - ONE;
  localparam logic signed [PW-1:0]  SAT_MIN       = ~SAT_MAX;
  localparam logic signed [PW-1:0]  ROUND_BIAS    = ONE << (2*F - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_MAC   = 3'd2,
    S_SCALE = 3'd3,
    S_OUT   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic                         causal_q;
  logic [DATA_WIDTH-1:0]        scale_q;
  logic [HW-1:0]                head_q;
  logic [LW-1:0]                row_q;
  logic [LW-1:0]                col_q;
  logic [KW-1:0]                k_q;
  logic signed [ACC_WIDTH-1:0]  acc;

  logic                         masked;
  logic                         handshake;
  logic                         is_last;
  logic [IW-1:0]                q_idx;
  logic [IW-1:0]                k_idx;
  logic signed [2*DATA_WIDTH-1:0] q_ext;
  logic signed [2*DATA_WIDTH-1:0] k_ext;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [PW-1:0]         acc_x;
  logic signed [PW-1:0]         scl_x;
  logic signed [PW-1:0]         scaled;
  logic signed [PW-1:0]         shifted;
  logic [DATA_WIDTH-1:0]        sat_score;

  logic signed [DATA_WIDTH-1:0] q_elem [N];
  logic signed [DATA_WIDTH-1:0] k_elem [N];

  // Flat tensor buses viewed as element arrays for the MAC operand muxes.
  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign q_elem[gi] = Q_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign k_elem[gi] = K_in[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign masked    = causal_q && (col_q > row_q);
  assign handshake = (state == S_OUT) && score_ready;
  assign is_last   = (head_q == HW'(H-1)) && (row_q == LW'(L-1)) && (col_q == LW'(L-1));

  // Operand selection and one full-precision product per MAC cycle.
  always_comb begin
    q_idx    = IW'((int'(head_q)*L + int'(row_q))*E + int'(k_q));
    k_idx    = IW'((int'(head_q)*L + int'(col_q))*E + int'(k_q));
    q_ext    = {{DATA_WIDTH{q_elem[q_idx][DATA_WIDTH-1]}}, q_elem[q_idx]};
    k_ext    = {{DATA_WIDTH{k_elem[k_idx][DATA_WIDTH-1]}}, k_elem[k_idx]};
    prod     = q_ext * k_ext;
    prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  end

  // Scale the accumulator, round half-up at 2F fraction bits, then saturate.
  always_comb begin
    acc_x   = {{(DATA_WIDTH+1){acc[ACC_WIDTH-1]}}, acc};
    scl_x   = {{(ACC_WIDTH+1){1'b0}}, scale_q};
    scaled  = acc_x * scl_x;
    shifted = (scaled + ROUND_BIAS) >>> (2*F);
    if (shifted > SAT_MAX) begin
      sat_score = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_score = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_score = shifted[DATA_WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_CHECK;
      S_CHECK: next_state = masked ? S_OUT : S_MAC;
      S_MAC:   if (k_q == KW'(E-1)) next_state = S_SCALE;
      S_SCALE: next_state = S_OUT;
      S_OUT:   if (handshake) next_state = score_last ? S_DONE : S_CHECK;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Datapath, index walk and registered stream outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      causal_q    <= 1'b0;
      scale_q     <= '0;
      head_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      k_q         <= '0;
      acc         <= '0;
      score_out   <= '0;
      score_head  <= '0;
      score_row   <= '0;
      score_col   <= '0;
      score_valid <= 1'b0;
      score_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            causal_q <= causal_en;
            scale_q  <= scale_ovr_en ? scale_in : DEFAULT_SCALE;
            head_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
          end
        end
        S_CHECK: begin
          if (masked) begin
            score_out  <= MASK_SCORE;
            score_head <= head_q;
            score_row  <= row_q;
            score_col  <= col_q;
          end else begin
            acc <= '0;
            k_q <= '0;
          end
        end
        S_MAC: begin
          acc <= acc + prod_ext;
          k_q <= k_q + KW'(1);
        end
        S_SCALE: begin
          score_out  <= sat_score;
          score_head <= head_q;
          score_row  <= row_q;
          score_col  <= col_q;
        end
        S_OUT: begin
          if (handshake) begin
            if (col_q == LW'(L-1)) begin
              col_q <= '0;
              if (row_q == LW'(L-1)) begin
                row_q  <= '0;
                head_q <= (head_q == HW'(H-1)) ? '0 : head_q + HW'(1);
              end else begin
                row_q <= row_q + LW'(1);
              end
            end else begin
              col_q <= col_q + LW'(1);
            end
          end
        end
        default: ;
      endcase
      // Flags follow the state being entered so they line up with it.
      score_valid <= (next_state == S_OUT);
      score_last  <= (next_state == S_OUT) && is_last;
      busy        <= (next_state != S_IDLE);
      done        <= (next_state == S_DONE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_attention_score_mh.sv
`default_nettype none
// ============================================================================
//  Module      : tb_attention_score_mh
//  Description : Self-checking bench for attention_score_mh (DW=16, L=4,
//                H=2, E=4): vector table plus randomized jobs against a
//                plain-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_attention_score_mh;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int H  = 2;
  localparam int E  = 4;
  localparam int NB = H * L * L;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 causal_en = 1'b0;
  logic                 scale_ovr_en = 1'b0;
  logic [DW-1:0]        scale_in = '0;
  logic [H*L*E*DW-1:0]  Q_in = '0;
  logic [H*L*E*DW-1:0]  K_in = '0;
  logic [DW-1:0]        score_out;
  logic                 score_valid;
  logic                 score_ready = 1'b1;
  logic [0:0]           score_head;
  logic [1:0]           score_row;
  logic [1:0]           score_col;
  logic                 score_last;
  logic                 busy;
  logic                 done;

  attention_score_mh #(.DATA_WIDTH(DW), .L(L), .H(H), .E(E)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .causal_en(causal_en),
    .scale_ovr_en(scale_ovr_en), .scale_in(scale_in), .Q_in(Q_in), .K_in(K_in),
    .score_out(score_out), .score_valid(score_valid), .score_ready(score_ready),
    .score_head(score_head), .score_row(score_row), .score_col(score_col),
    .score_last(score_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int qa [H][L][E];
  int ka [H][L][E];
  bit job_causal;
  int job_scale;
  int def_scale;

  typedef struct {
    string       name;
    bit          causal;
    bit          ovr;
    logic [15:0] scl;
    logic [15:0] q0, qr, k0, kr;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs [6];

  task automatic chk_eq(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pack();
    for (int h = 0; h < H; h++)
      for (int r = 0; r < L; r++)
        for (int e = 0; e < E; e++) begin
          Q_in[((h*L+r)*E+e)*DW +: DW] = 16'(qa[h][r][e]);
          K_in[((h*L+r)*E+e)*DW +: DW] = 16'(ka[h][r][e]);
        end
  endtask

  task automatic fill_const(input logic [15:0] q0, qr, k0, kr);
    for (int h = 0; h < H; h++)
      for (int r = 0; r < L; r++)
        for (int e = 0; e < E; e++) begin
          qa[h][r][e] = int'($signed((e == 0) ? q0 : qr));
          ka[h][r][e] = int'($signed((e == 0) ? k0 : kr));
        end
    pack();
  endtask

  task automatic fill_rand();
    for (int h = 0; h < H; h++)
      for (int r = 0; r < L; r++)
        for (int e = 0; e < E; e++) begin
          qa[h][r][e] = int'($signed(16'($urandom)));
          ka[h][r][e] = int'($signed(16'($urandom)));
        end
    pack();
  endtask

  // Reference: S[h][r][c] = sat(round(sum_e Q*K * scale / 2^30)).
  function automatic logic [15:0] model(input int h, input int r, input int c);
    longint acc, p, rnd;
    if (job_causal && c > r) return 16'h8000;
    acc = 0;
    for (int e = 0; e < E; e++) acc += longint'(qa[h][r][e]) * longint'(ka[h][c][e]);
    p   = acc * longint'(job_scale);
    rnd = (p + (longint'(1) << 29)) >>> 30;
    if (rnd > 32767) rnd = 32767;
    if (rnd < -32768) rnd = -32768;
    return 16'(rnd);
  endfunction

  // Run one full job; bp = random backpressure, abuse = start/mode noise while busy.
  task automatic run_job(input bit causal, input bit ovr, input logic [15:0] scl,
                         input bit use_tbl, input logic [15:0] tbl_exp,
                         input bit bp, input bit abuse);
    int beats, cyc, prev_hs, stall, eh, er, ec, gap;
    bit pend;
    logic [15:0] p_score, expv;
    logic [5:0]  p_tag;
    job_causal = causal;
    job_scale  = ovr ? int'(scl) : def_scale;
    @(negedge clk);
    causal_en = causal; scale_ovr_en = ovr; scale_in = scl; start = 1'b1; score_ready = 1'b1;
    beats = 0; cyc = 0; prev_hs = 0; stall = 0; pend = 1'b0; p_score = '0; p_tag = '0;
    while (beats < NB && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (abuse) begin
        start = 1'($urandom_range(0, 1)); causal_en = 1'($urandom_range(0, 1));
        scale_ovr_en = 1'($urandom_range(0, 1)); scale_in = 16'($urandom);
      end else begin
        start = 1'b0;
      end
      if (bp) begin
        if (score_valid && beats == 2 && stall < 5) begin
          score_ready = 1'b0; stall++;
        end else begin
          score_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        score_ready = 1'b1;
      end
      if (pend) begin
        chk_eq("valid_held", score_valid, 1);
        chk_eq("stall_score", score_out, p_score);
        chk_eq("stall_tag", {score_last, score_head, score_row, score_col}, p_tag);
      end
      if (score_valid && score_ready) begin
        eh = beats / (L*L); er = (beats / L) % L; ec = beats % L;
        expv = use_tbl ? ((causal && ec > er) ? 16'h8000 : tbl_exp) : model(eh, er, ec);
        chk_eq("score", score_out, expv);
        chk_eq("index", {score_head, score_row, score_col}, eh*16 + er*4 + ec);
        chk_eq("last", score_last, (beats == NB-1));
        if (!bp) begin
          gap = (causal && ec > er) ? 2 : E + 3;
          chk_eq("latency", cyc - prev_hs, gap);
        end
        prev_hs = cyc; beats++; pend = 1'b0;
      end else if (score_valid) begin
        pend = 1'b1; p_score = score_out;
        p_tag = {score_last, score_head, score_row, score_col};
      end else begin
        pend = 1'b0;
      end
    end
    start = 1'b0; score_ready = 1'b1;
    if (beats < NB) chk_eq("job_timeout_beats", beats, NB);
    @(negedge clk);
    chk_eq("done_pulse", done, 1);
    chk_eq("valid_after_last", score_valid, 0);
    start = abuse;  // a start coinciding with DONE must be ignored
    @(negedge clk);
    start = 1'b0;
    chk_eq("done_cleared", done, 0);
    chk_eq("idle_after_done", busy, 0);
  endtask

  initial begin
    int n, guard;
    def_scale = int'(32768.0 / $sqrt(real'(E)));
    if (def_scale > 32767) def_scale = 32767;

    vecs[0] = '{"basic",     1'b0, 1'b0, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vecs[1] = '{"causal",    1'b1, 1'b0, 16'h0000, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 16'h4000};
    vecs[2] = '{"sat_pos",   1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    vecs[3] = '{"sat_neg",   1'b0, 1'b1, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
    vecs[4] = '{"round_up",  1'b0, 1'b1, 16'h4000, 16'h0100, 16'h0000, 16'h0080, 16'h0000, 16'h0001};
    vecs[5] = '{"round_dn",  1'b0, 1'b1, 16'h4000, 16'h0100, 16'h0000, 16'hFF80, 16'h0000, 16'h0000};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_eq("rst_valid", score_valid, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_score", score_out, 0);
    chk_eq("rst_last", score_last, 0);
    chk_eq("rst_index", {score_head, score_row, score_col}, 0);

    for (int i = 0; i < 6; i++) begin
      fill_const(vecs[i].q0, vecs[i].qr, vecs[i].k0, vecs[i].kr);
      run_job(vecs[i].causal, vecs[i].ovr, vecs[i].scl, 1'b1, vecs[i].exp, 1'b0, 1'b0);
    end

    // Randomized jobs with backpressure and start/mode noise while busy.
    for (int j = 0; j < 3; j++) begin
      fill_rand();
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
              1'b0, 16'h0000, 1'b1, 1'b1);
    end

    // Reset during the MAC of beat 5 abandons the job.
    fill_const(16'h4000, 16'h4000, 16'h4000, 16'h4000);
    @(negedge clk);
    causal_en = 1'b0; scale_ovr_en = 1'b0; start = 1'b1; score_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 4 && guard < 200) begin
      @(negedge clk);
      start = 1'b0; guard++;
      if (score_valid) n++;
    end
    chk_eq("pre_reset_beats", n, 4);
    @(negedge clk);
    @(negedge clk);
    chk_eq("mac_busy", busy, 1);
    chk_eq("mac_valid", score_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_eq("midrst_valid", score_valid, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_score", score_out, 0);
    chk_eq("midrst_index", {score_head, score_row, score_col}, 0);
    repeat (E + 4) @(negedge clk);
    chk_eq("no_beats_after_rst", score_valid, 0);
    chk_eq("still_idle", busy, 0);

    // Fresh job after the abandoned one, checked against the model.
    fill_rand();
    run_job(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
